// File: rtl/hilo_muldiv_if.sv
// HI/LO unit bus: operation request, operands, ALU product and HI/LO/status results.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (output start, op, a, b, prod_lo, prod_hi,
                  input  hi, lo, busy, done, dz);
  modport slave  (input  start, op, a, b, prod_lo, prod_hi,
                  output hi, lo, busy, done, dz);
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO registers with product write, MTHI/MTLO and a 32-step restoring divider.
// Optional signed divide (op 100) is enabled by defining SIGNED_DIV_EN.
module hilo_muldiv #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hilo_muldiv_if.slave  bus
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIVU = 3'b001;
  localparam logic [2:0] OP_MTHI = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hi_reg, hi_next, lo_reg, lo_next;
  logic [WIDTH-1:0] rem_reg, rem_next, quo_reg, quo_next, dvs_reg, dvs_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             dz_reg, dz_next;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step, quo_step, rem_fin, quo_fin, a_mag, b_mag;
  logic             div_req;

`ifdef SIGNED_DIV_EN
  localparam logic [2:0] OP_DIV = 3'b100;
  logic is_signed, a_neg, b_neg;
  logic neg_q_reg, neg_q_next, neg_r_reg, neg_r_next;

  // Signed divide runs the unsigned core on magnitudes and fixes signs at the end.
  assign is_signed = (bus.op == OP_DIV);
  assign a_neg     = is_signed & bus.a[WIDTH-1];
  assign b_neg     = is_signed & bus.b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;
  assign div_req   = (bus.op == OP_DIVU) || is_signed;
  assign quo_fin   = neg_q_reg ? -quo_step : quo_step;
  assign rem_fin   = neg_r_reg ? -rem_step : rem_step;
`else
  assign a_mag   = bus.a;
  assign b_mag   = bus.b;
  assign div_req = (bus.op == OP_DIVU);
  assign quo_fin = quo_step;
  assign rem_fin = rem_step;
`endif

  // One restoring step: shift {rem,quo} left, keep the difference when it does not borrow.
  always_comb begin
    trial = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, dvs_reg};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_reg[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
      quo_step = {quo_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_next = state_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    dvs_next   = dvs_reg;
    cnt_next   = cnt_reg;
    dz_next    = dz_reg;
`ifdef SIGNED_DIV_EN
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
`endif
    case (state_reg)
      DIV: begin
        rem_next = rem_step;
        quo_next = quo_step;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          hi_next    = rem_fin;
          lo_next    = quo_fin;
          dz_next    = 1'b0;
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
        if (bus.start) begin
          if (div_req) begin
            if (bus.b == '0) begin
              hi_next    = bus.a;
              lo_next    = '1;
              dz_next    = 1'b1;
              state_next = DONE;
            end else begin
              rem_next   = '0;
              quo_next   = a_mag;
              dvs_next   = b_mag;
              cnt_next   = CW'(DIV_CYCLES);
              state_next = DIV;
`ifdef SIGNED_DIV_EN
              neg_q_next = a_neg ^ b_neg;
              neg_r_next = a_neg;
`endif
            end
          end else begin
            case (bus.op)
              OP_MULT: begin
                hi_next = bus.prod_hi;
                lo_next = bus.prod_lo;
              end
              OP_MTHI: hi_next = bus.a;
              OP_MTLO: lo_next = bus.a;
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      hi_reg    <= '0;
      lo_reg    <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      cnt_reg   <= '0;
      dz_reg    <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      dvs_reg   <= dvs_next;
      cnt_reg   <= cnt_next;
      dz_reg    <= dz_next;
`ifdef SIGNED_DIV_EN
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
`endif
    end
  end

  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
  assign bus.dz   = dz_reg;
  assign bus.busy = (state_reg == DIV);
  assign bus.done = (state_reg == DONE);
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed vector bench for hilo_muldiv: table of operations plus busy/reset/DONE-accept sequences.
module tb_hilo_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  hilo_muldiv_if #(.WIDTH(32)) bus ();

  hilo_muldiv #(.WIDTH(32), .DIV_CYCLES(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ph, pl;
    logic [31:0] ehi, elo;
    logic        edz;
    int          ebusy, edone;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("ok   %s = %h", name, act);
  endtask

  // Issue one op, then follow it until neither busy nor done, counting both.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, ph, pl,
                        output int bc, output int dc, output bit to);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.prod_hi = ph; bus.prod_lo = pl;
    @(negedge clk);
    bus.start = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy && !bus.done) break;
      if (bus.busy) bc++;
      if (bus.done) dc++;
      @(negedge clk);
    end
    to = bus.busy || bus.done;
  endtask

  initial begin
    int bc, dc, k;
    bit to;
    bus.start = 1'b0; bus.op = 3'b0; bus.a = '0; bus.b = '0; bus.prod_hi = '0; bus.prod_lo = '0;

    //                op      a             b             ph        pl        ehi           elo           dz  busy done
    vecs.push_back('{3'b000, 32'h0,        32'h0,        32'h1,    32'h2,    32'h1,        32'h2,        0,  0,   0});
    vecs.push_back('{3'b010, 32'hDEADBEEF, 32'h0,        32'h0,    32'h0,    32'hDEADBEEF, 32'h2,        0,  0,   0});
    vecs.push_back('{3'b011, 32'h12345678, 32'h0,        32'h0,    32'h0,    32'hDEADBEEF, 32'h12345678, 0,  0,   0});
    vecs.push_back('{3'b001, 32'd100,      32'd7,        32'h0,    32'h0,    32'd2,        32'd14,       0,  32,  1});
    vecs.push_back('{3'b001, 32'd5,        32'd0,        32'h0,    32'h0,    32'd5,        32'hFFFFFFFF, 1,  0,   1});
    vecs.push_back('{3'b011, 32'd9,        32'h0,        32'h0,    32'h0,    32'd5,        32'd9,        1,  0,   0});
    vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'd1,        32'h0,    32'h0,    32'h0,        32'hFFFFFFFF, 0,  32,  1});
    vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,    32'h0,    32'h0,        32'h1,        0,  32,  1});
    vecs.push_back('{3'b001, 32'd3,        32'h80000000, 32'h0,    32'h0,    32'd3,        32'h0,        0,  32,  1});
    vecs.push_back('{3'b001, 32'h80000000, 32'd3,        32'h0,    32'h0,    32'd2,        32'h2AAAAAAA, 0,  32,  1});
    vecs.push_back('{3'b001, 32'd1000000,  32'd1000,     32'h0,    32'h0,    32'h0,        32'd1000,     0,  32,  1});
    vecs.push_back('{3'b111, 32'h55,       32'h1,        32'h77,   32'h88,   32'h0,        32'd1000,     0,  0,   0});
`ifdef SIGNED_DIV_EN
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'h0,    32'h0,    32'hFFFFFFFF, 32'hFFFFFFFD, 0,  32,  1});
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h0,    32'h0,    32'h0,        32'h80000000, 0,  32,  1});
    vecs.push_back('{3'b100, 32'd7,        32'hFFFFFFFE, 32'h0,    32'h0,    32'h1,        32'hFFFFFFFD, 0,  32,  1});
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd0,        32'h0,    32'h0,    32'hFFFFFFF9, 32'hFFFFFFFF, 1,  0,   1});
`else
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'h0,    32'h0,    32'h0,        32'd1000,     0,  0,   0});
`endif

    #2;
    check("reset.hi", bus.hi, 32'h0);
    check("reset.lo", bus.lo, 32'h0);
    check("reset.flags", {29'b0, bus.busy, bus.done, bus.dz}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ph, vecs[i].pl, bc, dc, to);
      check($sformatf("v%0d.timeout", i), {31'b0, to}, 32'h0);
      check($sformatf("v%0d.hi", i), bus.hi, vecs[i].ehi);
      check($sformatf("v%0d.lo", i), bus.lo, vecs[i].elo);
      check($sformatf("v%0d.dz", i), {31'b0, bus.dz}, {31'b0, vecs[i].edz});
      check($sformatf("v%0d.busy_cycles", i), bc, vecs[i].ebusy);
      check($sformatf("v%0d.done_cycles", i), dc, vecs[i].edone);
    end

    // A new op accepted in the DONE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 40) begin @(negedge clk); k++; end
    check("dacc.reached_done", {31'b0, bus.done}, 32'h1);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'h77;
    @(negedge clk);
    bus.start = 1'b0;
    check("dacc.hi", bus.hi, 32'h77);
    check("dacc.lo", bus.lo, 32'd14);
    check("dacc.flags", {30'b0, bus.busy, bus.done}, 32'h0);

    // Divide by zero sets dz, then a divide is interrupted by MTHI (ignored) and reset.
    run_op(3'b001, 32'd5, 32'd0, 32'h0, 32'h0, bc, dc, to);
    check("seq.dz_set", {31'b0, bus.dz}, 32'h1);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'hAA;
    @(negedge clk);
    bus.start = 1'b0;
    check("seq.mthi_ignored", bus.hi, 32'd5);
    check("seq.still_busy", {31'b0, bus.busy}, 32'h1);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("seq.rst.hi", bus.hi, 32'h0);
    check("seq.rst.lo", bus.lo, 32'h0);
    check("seq.rst.flags", {29'b0, bus.busy, bus.done, bus.dz}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0; bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dc++;
      if (bus.busy) bc++;
    end
    check("seq.no_done_after_rst", dc, 0);
    check("seq.no_busy_after_rst", bc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
